div_ratio_checker: RTL and testbench
====================================

Name: div_ratio_checker

Overview:
- Downstream consumer of the even clock divider (div2/div4/div6 outputs). Runs in the same `clk` domain.
- Continuously measures each divided signal's high and low run lengths. Declares per-channel lock after a run of correct half-periods.
- Flags and counts faults once locked: wrong half-period, or a stuck output.
- Used in silicon as a built-in divider health monitor and in sim as a self-checking sink.

Parameters:
- NUM_CH, 3: number of monitored channels. Channel k expects divide ratio 2*(k+1), i.e. half-period H_k = k+1 clk cycles.
- LOCK_RUNS, 4: consecutive correct half-periods required to enter LOCKED.
- RUN_W, 4: run-length counter width; saturates at 2^RUN_W-1.
- CNT_W, 8: per-channel fault counter width; saturating.

Ports:
- clk  input  1  system clock, same clock that drives the divider.
- resetn  input  1  asynchronous active-low reset.
- en  input  1  monitor enable; low forces all channels to IDLE.
- clr_err  input  1  synchronous clear of err_sticky and fault_cnt.
- div_in  input  NUM_CH  divided signals; bit0=div2, bit1=div4, bit2=div6.
- locked  output  NUM_CH  channel k is in LOCKED state.
- fault_pulse  output  NUM_CH  one-cycle pulse, cycle after a fault is detected.
- err_sticky  output  NUM_CH  set on any fault; held until clr_err or reset.
- fault_cnt  output  NUM_CH*CNT_W  flattened saturating fault counts; channel k at [k*CNT_W +: CNT_W].

Behaviour:
- Interface: one clock `clk`; reset `resetn` is asynchronous, active-low. All state clears on resetn low, regardless of clk.
- Reset values: locked=0, fault_pulse=0, err_sticky=0, fault_cnt=0, d_q=0, run=0, good_cnt=0, state=IDLE.
- Per-channel datapath:
  - d_q <= div_in[k] every cycle; edge = div_in[k] != d_q.
  - On edge: evaluate run against H_k, then run <= 1.
  - Otherwise: run <= run+1, saturating at 2^RUN_W-1.
  - A run equal to H_k is good.
- States: IDLE, SEEK, MEASURE, LOCKED.
  - IDLE: en=1 -> SEEK. Exiting IDLE does not clear err_sticky or fault_cnt.
  - SEEK: first edge -> MEASURE, good_cnt=0. The run ending at that edge is not judged.
  - MEASURE:
    - edge with good run: good_cnt+1. On reaching LOCK_RUNS -> LOCKED.
    - edge with bad run: good_cnt=0, stay in MEASURE, no fault.
  - LOCKED: fault when either condition holds:
    - (a) edge with run != H_k;
    - (b) no edge and run >= H_k (stuck).
    - On fault: -> MEASURE, good_cnt=0, err_sticky=1, fault_cnt+1 (saturating), fault_pulse=1 next cycle.
  - en=0 in any state: -> IDLE next cycle; locked drops the same cycle the state register updates.
- Timing of outputs:
  - locked is a registered decode of state==LOCKED.
  - Fault detection latency: 1 cycle from the offending sample to fault_pulse, err_sticky and the fault_cnt update.
- Simultaneous events:
  - clr_err with a fault in the same cycle: clear applies first, so err_sticky=1 and fault_cnt=1.
  - clr_err has no effect on state or locked.
- fault_cnt at max stays at max; err_sticky still set; fault_pulse still issued.
- Reset mid-operation: immediate return to reset values. After release the channel re-enters SEEK if en=1.
- Widths: the run compare uses RUN_W bits. NUM_CH must satisfy H_k <= 2^RUN_W-2 (elaboration-time assertion).

Decomposition:
- Package div_chk_pkg holds:
  - state enum {IDLE, SEEK, MEASURE, LOCKED};
  - default RUN_W/CNT_W localparams;
  - function exp_half(k) returning k+1.
- Sub-module div_chk_channel (one channel, parameter H), instantiated NUM_CH times via generate. Top level only fans out en/clr_err and packs the outputs.

Test Plan:
- Reset, en=1, ideal divider (div2/div4/div6) -> locked[0] high within 6 cycles, locked[1] within 11, locked[2] within 16; err_sticky=0, fault_cnt=0 for 200 cycles.
- Locked, then div4 held high for 4 cycles -> fault_pulse[1] for exactly 1 cycle, 1 cycle after the 2nd same-level sample; err_sticky=3'b010, fault_cnt[1]=1; relock within 11 cycles after toggling resumes.
- Locked, div6 produces one 2-cycle high phase -> fault_pulse[2] once, fault_cnt[2]=1, channels 0/1 stay locked.
- Repeated faults on div2 (300 injected) -> fault_cnt[0] saturates at 255; fault_pulse continues on each fault.
- clr_err asserted in the same cycle as a detected fault -> err_sticky=1, fault_cnt=1 afterwards. clr_err alone -> both 0, locked unchanged.
- resetn pulsed low mid-lock, and en dropped mid-MEASURE -> all outputs 0 immediately on reset; on en=0 locked=0 next cycle with counts retained; relock after release or re-enable.

Source files
------------

// File: rtl/div_chk_pkg.sv
// Types and defaults shared by the divider ratio checker and its channels.
package div_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEK    = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } chk_state_e;

    localparam int DEF_RUN_W = 4;
    localparam int DEF_CNT_W = 8;

    // Channel k watches the divide-by-2*(k+1) output, so its half-period is k+1 cycles.
    function automatic int exp_half(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/div_chk_channel.sv
// One divider channel: run-length measurement, lock FSM and fault bookkeeping.
// All outputs registered, 1 cycle after the offending sample; pure sink, never stalls.
module div_chk_channel
    import div_chk_pkg::*;
#(
    parameter int H         = 1,
    parameter int LOCK_RUNS = 4,
    parameter int RUN_W     = DEF_RUN_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             en_i,
    input  logic             clr_err_i,
    input  logic             div_i,
    output logic             locked_o,
    output logic             fault_pulse_o,
    output logic             err_sticky_o,
    output logic [CNT_W-1:0] fault_cnt_o
);

    localparam int               GOOD_W    = $clog2(LOCK_RUNS + 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [RUN_W-1:0] H_RUN     = RUN_W'(H);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_RUNS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // The stuck check needs run to reach H before saturating, so H must leave headroom.
    if (H < 1 || H > (2 ** RUN_W) - 2) begin : g_bad_half_period
        $error("div_chk_channel: half-period %0d does not fit RUN_W=%0d", H, RUN_W);
    end

    chk_state_e        state_q, state_d;
    logic              d_q;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              locked_q;
    logic              fault_pulse_q;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic edge_det;
    logic run_ok;
    logic fault;

    assign edge_det = (div_i != d_q);
    assign run_ok   = (run_q == H_RUN);

    always_comb begin
        run_d = run_q;
        if (edge_det) begin
            run_d = RUN_W'(1);
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        fault   = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            good_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEEK;
                end
                SEEK: begin
                    if (edge_det) begin
                        state_d = MEASURE;
                        good_d  = '0;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        if (!run_ok) begin
                            good_d = '0;
                        end else if (good_q == GOOD_LAST) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if ((edge_det && !run_ok) || (!edge_det && (run_q >= H_RUN))) begin
                        fault   = 1'b1;
                        state_d = MEASURE;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    good_d  = '0;
                end
            endcase
        end
    end

    // Clear is applied before the increment so a coincident fault still leaves a count of one.
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (clr_err_i) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
        if (fault) begin
            err_d = 1'b1;
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= IDLE;
            d_q           <= 1'b0;
            run_q         <= '0;
            good_q        <= '0;
            locked_q      <= 1'b0;
            fault_pulse_q <= 1'b0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            d_q           <= div_i;
            run_q         <= run_d;
            good_q        <= good_d;
            locked_q      <= (state_d == LOCKED);
            fault_pulse_q <= fault;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign locked_o      = locked_q;
    assign fault_pulse_o = fault_pulse_q;
    assign err_sticky_o  = err_q;
    assign fault_cnt_o   = cnt_q;

endmodule

// File: rtl/div_ratio_checker.sv
// Health monitor for the even clock divider: one checker channel per divided output.
// Outputs registered, 1 cycle after the offending sample; pure sink, never stalls.
module div_ratio_checker
    import div_chk_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int LOCK_RUNS = 4,
    parameter int RUN_W     = DEF_RUN_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    en,
    input  logic                    clr_err,
    input  logic [NUM_CH-1:0]       div_in,
    output logic [NUM_CH-1:0]       locked,
    output logic [NUM_CH-1:0]       fault_pulse,
    output logic [NUM_CH-1:0]       err_sticky,
    output logic [NUM_CH*CNT_W-1:0] fault_cnt
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        div_chk_channel #(
            .H         (exp_half(k)),
            .LOCK_RUNS (LOCK_RUNS),
            .RUN_W     (RUN_W),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk_i         (clk),
            .resetn_i      (resetn),
            .en_i          (en),
            .clr_err_i     (clr_err),
            .div_i         (div_in[k]),
            .locked_o      (locked[k]),
            .fault_pulse_o (fault_pulse[k]),
            .err_sticky_o  (err_sticky[k]),
            .fault_cnt_o   (fault_cnt[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_div_ratio_checker.sv
// Directed bench: ideal div2/div4/div6 model with per-channel hold/skip fault injection.
module tb_div_ratio_checker;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic        clr_err;
    logic [2:0]  div_in;
    wire  [2:0]  locked;
    wire  [2:0]  fault_pulse;
    wire  [2:0]  err_sticky;
    wire  [23:0] fault_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int   dcnt [3];
    logic lvl  [3];
    logic hold [3];
    logic skip [3];
    logic rose [3];

    always #5 clk = ~clk;

    div_ratio_checker #(
        .NUM_CH    (3),
        .LOCK_RUNS (4),
        .RUN_W     (4),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .en          (en),
        .clr_err     (clr_err),
        .div_in      (div_in),
        .locked      (locked),
        .fault_pulse (fault_pulse),
        .err_sticky  (err_sticky),
        .fault_cnt   (fault_cnt)
    );

    function automatic logic [7:0] fcnt(input int k);
        return fault_cnt[k*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_le(input string tag, input int obs, input int lim);
        n_cmp++;
        assert (obs <= lim) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required <= %0d", tag, obs, lim);
        end
    endtask

    // Advance the divider model, present the new sample, then step past the clock edge
    // that captures it: outputs seen afterwards reflect the sample set in this call.
    task automatic tick();
        for (int k = 0; k < 3; k++) begin
            rose[k] = 1'b0;
            if (skip[k]) begin
                skip[k] = 1'b0;
                dcnt[k] = 0;
                lvl[k]  = ~lvl[k];
                rose[k] = lvl[k];
            end else if (!hold[k]) begin
                dcnt[k]++;
                if (dcnt[k] == k + 1) begin
                    dcnt[k] = 0;
                    lvl[k]  = ~lvl[k];
                    rose[k] = lvl[k];
                end
            end
            div_in[k] = lvl[k];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input int k);
        int g;
        g = 0;
        do begin
            tick();
            g++;
        end while (!rose[k] && g < 12);
    endtask

    task automatic wait_lock(input int k, input int bound, input string tag);
        int i;
        i = 0;
        while (!locked[k] && i < 40) begin
            tick();
            i++;
        end
        chk_le(tag, i, bound);
    endtask

    task automatic lock_times(input string tag, input int b0, input int b1, input int b2);
        int t [3];
        for (int k = 0; k < 3; k++) t[k] = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (locked[k] && t[k] == 99) t[k] = i;
            end
        end
        chk_le({tag, "_ch0"}, t[0], b0);
        chk_le({tag, "_ch1"}, t[1], b1);
        chk_le({tag, "_ch2"}, t[2], b2);
    endtask

    initial begin
        logic [2:0]  acc_err;
        logic [23:0] acc_cnt;
        logic [2:0]  acc_lk;
        logic [2:0]  acc_pl;

        for (int k = 0; k < 3; k++) begin
            dcnt[k] = 0;
            lvl[k]  = 1'b0;
            hold[k] = 1'b0;
            skip[k] = 1'b0;
            rose[k] = 1'b0;
        end
        div_in  = 3'b000;
        resetn  = 1'b0;
        en      = 1'b0;
        clr_err = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_pulse", 32'(fault_pulse), 32'h0);
        chk("rst_err", 32'(err_sticky), 32'h0);
        chk("rst_cnt", 32'(fault_cnt), 32'h0);
        resetn = 1'b1;
        repeat (2) tick();
        chk("idle_no_lock", 32'(locked), 32'h0);

        // Ideal divider: lock within 6/11/16 cycles, then clean for 200 cycles
        en = 1'b1;
        lock_times("first_lock", 6, 11, 16);
        acc_err = '0;
        acc_cnt = '0;
        acc_pl  = '0;
        acc_lk  = 3'b111;
        for (int i = 0; i < 200; i++) begin
            tick();
            acc_err |= err_sticky;
            acc_cnt |= fault_cnt;
            acc_pl  |= fault_pulse;
            acc_lk  &= locked;
        end
        chk("clean_err", 32'(acc_err), 32'h0);
        chk("clean_cnt", 32'(acc_cnt), 32'h0);
        chk("clean_pulse", 32'(acc_pl), 32'h0);
        chk("clean_locked", 32'(acc_lk), 32'h7);

        // div4 held high for 4 samples
        wait_rise(1);
        hold[1] = 1'b1;
        tick();
        chk("div4_no_early_pulse", 32'(fault_pulse), 32'h0);
        tick();
        hold[1] = 1'b0;
        chk("div4_pulse", 32'(fault_pulse), 32'h2);
        chk("div4_err", 32'(err_sticky), 32'h2);
        chk("div4_cnt1", 32'(fcnt(1)), 32'h1);
        chk("div4_locked", 32'(locked), 32'h5);
        tick();
        chk("div4_pulse_once", 32'(fault_pulse), 32'h0);
        wait_lock(1, 11, "div4_relock");

        // div6 with one 2-cycle high phase
        chk("pre_div6_locked", 32'(locked), 32'h7);
        wait_rise(2);
        tick();
        skip[2] = 1'b1;
        tick();
        chk("div6_pulse", 32'(fault_pulse), 32'h4);
        chk("div6_cnt2", 32'(fcnt(2)), 32'h1);
        chk("div6_err", 32'(err_sticky), 32'h6);
        chk("div6_others_locked", 32'(locked), 32'h3);
        tick();
        chk("div6_pulse_once", 32'(fault_pulse), 32'h0);
        wait_lock(2, 20, "div6_relock");

        // 300 faults on div2: counter saturates, pulses keep coming
        for (int i = 0; i < 300; i++) begin
            wait_lock(0, 20, "div2_relock");
            hold[0] = 1'b1;
            tick();
            hold[0] = 1'b0;
            chk("div2_rep_pulse", 32'(fault_pulse[0]), 32'h1);
        end
        chk("div2_sat_cnt", 32'(fcnt(0)), 32'hff);
        chk("div2_sat_err", 32'(err_sticky), 32'h7);

        // clr_err coincident with a fault
        wait_lock(0, 20, "clr_pre_lock");
        hold[0] = 1'b1;
        clr_err = 1'b1;
        tick();
        hold[0] = 1'b0;
        clr_err = 1'b0;
        chk("clrf_err", 32'(err_sticky), 32'h1);
        chk("clrf_cnt0", 32'(fcnt(0)), 32'h1);
        chk("clrf_cnt1", 32'(fcnt(1)), 32'h0);
        chk("clrf_cnt2", 32'(fcnt(2)), 32'h0);
        chk("clrf_pulse", 32'(fault_pulse), 32'h1);

        // clr_err alone
        wait_lock(0, 20, "clr_relock");
        chk("clr_pre_locked", 32'(locked), 32'h7);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err", 32'(err_sticky), 32'h0);
        chk("clr_cnt", 32'(fault_cnt), 32'h0);
        chk("clr_locked", 32'(locked), 32'h7);

        // Asynchronous reset mid-lock
        wait_lock(0, 20, "rst_pre_lock");
        hold[0] = 1'b1;
        tick();
        hold[0] = 1'b0;
        chk("rst_pre_cnt0", 32'(fcnt(0)), 32'h1);
        wait_lock(0, 20, "rst_pre_relock");
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 32'h0);
        chk("arst_pulse", 32'(fault_pulse), 32'h0);
        chk("arst_err", 32'(err_sticky), 32'h0);
        chk("arst_cnt", 32'(fault_cnt), 32'h0);
        repeat (2) tick();
        resetn = 1'b1;
        lock_times("rst_relock", 6, 11, 16);

        // en dropped while channel 1 is back in MEASURE
        wait_rise(1);
        hold[1] = 1'b1;
        tick();
        tick();
        hold[1] = 1'b0;
        chk("en_pre_locked", 32'(locked), 32'h5);
        en = 1'b0;
        tick();
        chk("en_off_locked", 32'(locked), 32'h0);
        chk("en_off_err", 32'(err_sticky), 32'h2);
        chk("en_off_cnt1", 32'(fcnt(1)), 32'h1);
        tick();
        en = 1'b1;
        lock_times("en_relock", 6, 11, 16);
        chk("en_on_err", 32'(err_sticky), 32'h2);
        chk("en_on_cnt", 32'(fault_cnt), 32'h000100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
